// File: rtl/att_pd_pkg.sv
// Shared types, widths and saturation helper for the attitude PD sequencer.
package att_pd_pkg;

    typedef enum logic [2:0] {IDLE, ERR, DIFF, PMUL, DMUL, DONE} state_e;
    typedef enum logic [1:0] {AX_PTCH, AX_ROLL, AX_YAW} axis_e;

    localparam int ERR_W  = 10;
    localparam int DIFF_W = 7;
    localparam int COEF_W = 6;

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/att_pd_seq_err_queue.sv
// Per-axis circular history of saturated errors; read is combinational at the shared pointer.
// One write per DIFF cycle; pointer advances once per frame; no backpressure.
module pd_err_queue import att_pd_pkg::*; #(
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       axis_i,
    input  logic             we_i,
    input  logic [ERR_W-1:0] wdat_i,
    input  logic             adv_i,
    output logic [ERR_W-1:0] rdat_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    ptr_q;
    logic [ERR_W-1:0] mem_q [3][DEPTH];

    // The slot about to be overwritten is the oldest one, DEPTH frames back.
    assign rdat_o = mem_q[axis_i][ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int a = 0; a < 3; a++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[a][i] <= '0;
                end
            end
        end else begin
            if (we_i) begin
                mem_q[axis_i][ptr_q] <= wdat_i;
            end
            if (adv_i) begin
                ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/att_pd_seq.sv
// PD correction for pitch/roll/yaw on one shared multiplier; cmd_vld 12 edges after the accepting edge.
// No backpressure: vld while busy is dropped and recorded on the sticky ovr flag.
module att_pd_seq import att_pd_pkg::*; #(
    parameter int D_QUEUE_DEPTH = 12,
    parameter int P_COEF        = 6,
    parameter int D_COEF        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [15:0] ptch,
    input  logic [15:0] roll,
    input  logic [15:0] yaw,
    input  logic [15:0] d_ptch,
    input  logic [15:0] d_roll,
    input  logic [15:0] d_yaw,
    output logic [15:0] ptch_cmd,
    output logic [15:0] roll_cmd,
    output logic [15:0] yaw_cmd,
    output logic        cmd_vld,
    output logic        busy,
    output logic        ovr
);

    localparam logic signed [COEF_W-1:0] P_C = COEF_W'(P_COEF);
    localparam logic signed [COEF_W-1:0] D_C = COEF_W'(D_COEF);

    state_e                   state_q;
    axis_e                    axis_q;
    logic signed [15:0]       meas_q [3];
    logic signed [15:0]       des_q [3];
    logic signed [15:0]       stg_q [3];
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ERR_W-1:0]  err_d;
    logic signed [DIFF_W-1:0] dif_q;
    logic signed [DIFF_W-1:0] dif_d;
    logic signed [15:0]       pterm_q;
    logic [15:0]              ptch_cmd_q;
    logic [15:0]              roll_cmd_q;
    logic [15:0]              yaw_cmd_q;
    logic                     cmd_vld_q;
    logic                     busy_q;
    logic                     ovr_q;

    logic [ERR_W-1:0]         q_old;
    logic signed [16:0]       err_raw;
    logic signed [ERR_W:0]    dif_raw;
    logic signed [ERR_W-1:0]  mul_a;
    logic signed [COEF_W-1:0] mul_b;
    logic signed [15:0]       mul_p;
    logic signed [15:0]       sum_d;

    pd_err_queue #(
        .DEPTH  (D_QUEUE_DEPTH)
    ) u_queue (
        .clk    (clk),
        .rst    (rst),
        .axis_i (axis_q),
        .we_i   (state_q == DIFF),
        .wdat_i (err_q),
        .adv_i  (state_q == DONE),
        .rdat_o (q_old)
    );

    always_comb begin
        err_raw = {des_q[axis_q][15], des_q[axis_q]} - {meas_q[axis_q][15], meas_q[axis_q]};
        err_d   = ERR_W'(sat_s(32'(err_raw), ERR_W));
        dif_raw = {err_q[ERR_W-1], err_q} - {q_old[ERR_W-1], q_old};
        dif_d   = DIFF_W'(sat_s(32'(dif_raw), DIFF_W));
        // Shared multiplier: error x P in PMUL, saturated difference x D in DMUL.
        mul_a   = err_q;
        mul_b   = P_C;
        if (state_q == DMUL) begin
            mul_a = ERR_W'(dif_q);
            mul_b = D_C;
        end
        mul_p   = 16'(mul_a) * 16'(mul_b);
        sum_d   = pterm_q + mul_p;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            axis_q     <= AX_PTCH;
            err_q      <= '0;
            dif_q      <= '0;
            pterm_q    <= '0;
            for (int a = 0; a < 3; a++) begin
                meas_q[a] <= '0;
                des_q[a]  <= '0;
                stg_q[a]  <= '0;
            end
            ptch_cmd_q <= '0;
            roll_cmd_q <= '0;
            yaw_cmd_q  <= '0;
            cmd_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cmd_vld_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (vld) begin
                        meas_q[AX_PTCH] <= ptch;
                        meas_q[AX_ROLL] <= roll;
                        meas_q[AX_YAW]  <= yaw;
                        des_q[AX_PTCH]  <= d_ptch;
                        des_q[AX_ROLL]  <= d_roll;
                        des_q[AX_YAW]   <= d_yaw;
                        axis_q          <= AX_PTCH;
                        busy_q          <= 1'b1;
                        state_q         <= ERR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ERR: begin
                    err_q   <= err_d;
                    state_q <= DIFF;
                end
                DIFF: begin
                    dif_q   <= dif_d;
                    state_q <= PMUL;
                end
                PMUL: begin
                    pterm_q <= mul_p;
                    state_q <= DMUL;
                end
                DMUL: begin
                    stg_q[axis_q] <= sum_d;
                    if (axis_q == AX_YAW) begin
                        // Yaw's sum bypasses staging so all three commands update together.
                        ptch_cmd_q <= stg_q[AX_PTCH];
                        roll_cmd_q <= stg_q[AX_ROLL];
                        yaw_cmd_q  <= sum_d;
                        cmd_vld_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        axis_q  <= (axis_q == AX_PTCH) ? AX_ROLL : AX_YAW;
                        state_q <= ERR;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (vld && busy_q) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign ptch_cmd = ptch_cmd_q;
    assign roll_cmd = roll_cmd_q;
    assign yaw_cmd  = yaw_cmd_q;
    assign cmd_vld  = cmd_vld_q;
    assign busy     = busy_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_att_pd_seq.sv
// Bench for att_pd_seq: vector table, hand sequences for overrun/reset/wrap, random frames vs model.
module tb_att_pd_seq;

    localparam int DEPTH = 12;
    localparam int PC    = 6;
    localparam int DC    = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [15:0] ptch = '0, roll = '0, yaw = '0;
    logic [15:0] d_ptch = '0, d_roll = '0, d_yaw = '0;
    logic [15:0] ptch_cmd, roll_cmd, yaw_cmd;
    logic        cmd_vld, busy, ovr;

    att_pd_seq #(
        .D_QUEUE_DEPTH (DEPTH),
        .P_COEF        (PC),
        .D_COEF        (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .ptch     (ptch),
        .roll     (roll),
        .yaw      (yaw),
        .d_ptch   (d_ptch),
        .d_roll   (d_roll),
        .d_yaw    (d_yaw),
        .ptch_cmd (ptch_cmd),
        .roll_cmd (roll_cmd),
        .yaw_cmd  (yaw_cmd),
        .cmd_vld  (cmd_vld),
        .busy     (busy),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int p;
        int r;
        int y;
        int acc;
    } sb_t;

    typedef struct {
        int mp, mr, my, dp, dr, dy;
        int ep, er, ey;
    } vec_t;

    sb_t  sbq[$];
    vec_t tab[4];
    int   n_vec = 0;
    int   n_err = 0;
    int   hist[3][DEPTH];
    int   mptr = 0;
    bit   prev_cv = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int x, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < DEPTH; i++) hist[a][i] = 0;
        end
        mptr = 0;
        sbq.delete();
    endtask

    task automatic model_frame(input int m0, m1, m2, d0, d1, d2, output int c0, c1, c2);
        int m[3];
        int d[3];
        int c[3];
        int e;
        int df;
        m = '{m0, m1, m2};
        d = '{d0, d1, d2};
        for (int a = 0; a < 3; a++) begin
            e  = sat(d[a] - m[a], 10);
            df = sat(e - hist[a][mptr], 7);
            hist[a][mptr] = e;
            c[a] = e * PC + df * DC;
        end
        mptr = (mptr + 1) % DEPTH;
        c0 = c[0];
        c1 = c[1];
        c2 = c[2];
    endtask

    // Called at a negedge; vld is sampled on the following posedge.
    task automatic send(input int mp, mr, my, dp, dr, dy, input bit use_model, input int ep, er, ey);
        int  cp, cr, cy;
        sb_t s;
        model_frame(mp, mr, my, dp, dr, dy, cp, cr, cy);
        s.p   = use_model ? cp : ep;
        s.r   = use_model ? cr : er;
        s.y   = use_model ? cy : ey;
        s.acc = cyc + 1;
        sbq.push_back(s);
        ptch = 16'(mp); roll = 16'(mr); yaw = 16'(my);
        d_ptch = 16'(dp); d_roll = 16'(dr); d_yaw = 16'(dy);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_cmd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cmd_vld) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_vld_timeout: got no pulse in 40 cycles, expected one (cycle %0d)", cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every cmd_vld pops one expected frame and checks latency and values.
    always @(negedge clk) begin
        sb_t e;
        if (prev_cv) chk("cmd_vld_width", int'(cmd_vld), 0);
        prev_cv = cmd_vld && !rst;
        if (cmd_vld && !rst) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_cmd_vld: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("latency", cyc, e.acc + 12);
                chk("ptch_cmd", int'($signed(ptch_cmd)), e.p);
                chk("roll_cmd", int'($signed(roll_cmd)), e.r);
                chk("yaw_cmd", int'($signed(yaw_cmd)), e.y);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int mv[3];
        int dv[3];
        tab[0] = '{0, 0, 0, 100, 0, 0, 1041, 0, 0};
        tab[1] = '{0, 2000, 0, 0, 0, 0, 0, -3520, 0};
        tab[2] = '{0, 0, 50, 0, 0, -300, 0, 0, -2548};
        tab[3] = '{3, -20, 32767, -7, 500, -32768, -130, 3507, -3520};

        do_reset();
        chk("rst_ptch_cmd", int'(ptch_cmd), 0);
        chk("rst_roll_cmd", int'(roll_cmd), 0);
        chk("rst_yaw_cmd", int'(yaw_cmd), 0);
        chk("rst_cmd_vld", int'(cmd_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(ovr), 0);

        @(negedge clk);
        send(0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        chk("busy_running", int'(busy), 1);
        wait_cmd();
        chk("busy_done", int'(busy), 0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send(tab[i].mp, tab[i].mr, tab[i].my, tab[i].dp, tab[i].dr, tab[i].dy,
                 1'b0, tab[i].ep, tab[i].er, tab[i].ey);
            wait_cmd();
            repeat (2) @(negedge clk);
        end

        // Queue wrap, issued back-to-back so each vld lands in DONE.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            send(0, 0, 0, 100, 0, 0, 1'b0, (i < 12) ? 1041 : 600, 0, 0);
            wait_cmd();
        end
        repeat (3) @(negedge clk);
        chk("ovr_after_back_to_back", int'(ovr), 0);

        // Overrun: vld in cycle 5 with different data must be ignored.
        do_reset();
        @(negedge clk);
        send(0, 0, 0, 100, 0, 0, 1'b0, 1041, 0, 0);
        repeat (4) @(negedge clk);
        d_ptch = 16'(-100);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        d_ptch = 16'(100);
        chk("ovr_set", int'(ovr), 1);
        wait_cmd();
        repeat (20) @(negedge clk);
        chk("ovr_sticky", int'(ovr), 1);
        chk("overrun_sb_drained", sbq.size(), 0);

        // Reset mid-frame: cmds return to 0, no pulse, queue cleared.
        do_reset();
        chk("ovr_cleared", int'(ovr), 0);
        @(negedge clk);
        send(0, 0, 0, 100, 0, 0, 1'b0, 1041, 0, 0);
        wait_cmd();
        @(negedge clk);
        send(0, 0, 0, 100, 0, 0, 1'b0, 1041, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ptch_cmd", int'(ptch_cmd), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        send(0, 0, 0, 100, 0, 0, 1'b0, 1041, 0, 0);
        wait_cmd();
        repeat (2) @(negedge clk);

        // rst and vld together: frame not accepted.
        rst = 1'b1;
        model_reset();
        d_ptch = 16'(100);
        vld = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        chk("rst_vld_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        send(0, 0, 0, 100, 0, 0, 1'b0, 1041, 0, 0);
        wait_cmd();

        // Random frames against the model, including queue wrap.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            for (int a = 0; a < 3; a++) begin
                mv[a] = int'($urandom_range(0, 2000)) - 1000;
                dv[a] = mv[a] + int'($urandom_range(0, 1400)) - 700;
            end
            send(mv[0], mv[1], mv[2], dv[0], dv[1], dv[2], 1'b1, 0, 0, 0);
            wait_cmd();
            if (i % 3 == 0) repeat (2) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("final_sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
